// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an optional circular return-address stack.
// Next PC priority: RESET > STALL > RET > CALL > branch condition > PC + 4.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; without it CALL acts as
// a plain jump, RET is ignored and the stack status outputs are constant.
module pc_sequencer #(
  parameter int unsigned   AW           = 32,
  parameter int unsigned   OFS_W        = 8,
  parameter int unsigned   RAS_DEPTH    = 4,
  parameter logic [AW-1:0] RESET_VECTOR = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BRANCH,
  input  logic             JUMP,
  input  logic             ZERO,
  input  logic             CALL,
  input  logic             RET,
  input  logic [OFS_W-1:0] OFFSET,
  output logic [AW-1:0]    PC,
  output logic [AW-1:0]    PC_4,
  output logic             TAKEN,
  output logic             RAS_FULL,
  output logic             RAS_EMPTY,
  output logic             RAS_ERR
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_d;
  logic [AW-1:0] w_pc_4;
  logic [AW-1:0] w_ofs_sx;
  logic [AW-1:0] w_target;
  logic          w_cond;
  logic          w_taken;

  assign w_pc_4   = r_pc + AW'(4);
  // Size cast of a signed operand sign-extends the word offset to AW bits.
  assign w_ofs_sx = AW'($signed(OFFSET));
  assign w_target = w_pc_4 + (w_ofs_sx << 2);
  // beq: JUMP=0 takes on zero; bne: JUMP=1 inverts; plain jump: BRANCH=0, JUMP=1.
  assign w_cond   = JUMP ^ (BRANCH & ZERO);

`ifdef PC_SEQUENCER_RAS_EN

  localparam int unsigned PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

  // r_wp is the next write slot; the top entry sits just below it (mod depth).
  logic [AW-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] w_wp_d;
  logic [PW-1:0] w_top_idx;
  logic [PW-1:0] w_widx;
  logic [PW:0]   r_cnt;
  logic [PW:0]   w_cnt_d;
  logic          r_err;
  logic          w_err_d;
  logic          w_we;
  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_top;

  assign w_top_idx = r_wp - PTR_ONE;
  assign w_top     = r_stack[w_top_idx];
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);

  // Next PC, stack pointer/count/error and the single stack write port.
  always_comb begin
    w_pc_d  = w_pc_4;
    w_taken = 1'b0;
    w_wp_d  = r_wp;
    w_cnt_d = r_cnt;
    w_err_d = r_err;
    w_we    = 1'b0;
    w_widx  = r_wp;
    if (STALL) begin
      w_pc_d = r_pc;
    end else if (RET) begin
      if (!w_empty) begin
        w_pc_d  = w_top;
        w_taken = 1'b1;
        if (CALL) begin
          // Pop and push in one go: overwrite the top in place.
          w_we   = 1'b1;
          w_widx = w_top_idx;
        end else begin
          w_wp_d  = w_top_idx;
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end else begin
        // Underflow falls through sequentially; a paired CALL still pushes.
        w_err_d = 1'b1;
        if (CALL) begin
          w_we    = 1'b1;
          w_wp_d  = r_wp + PTR_ONE;
          w_cnt_d = r_cnt + CNT_ONE;
        end
      end
    end else if (CALL) begin
      w_pc_d  = w_target;
      w_taken = 1'b1;
      w_we    = 1'b1;
      w_wp_d  = r_wp + PTR_ONE;
      // When full the write lands on the oldest slot and the count saturates.
      if (w_full) begin
        w_err_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + CNT_ONE;
      end
    end else if (w_cond) begin
      w_pc_d  = w_target;
      w_taken = 1'b1;
    end
  end

  // Stack bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wp  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_wp  <= w_wp_d;
      r_cnt <= w_cnt_d;
      r_err <= w_err_d;
    end
  end

  // Stack storage; contents are don't-care after reset so it has no reset.
  always_ff @(posedge CLK) begin
    if (!RESET && w_we) begin
      r_stack[w_widx] <= w_pc_4;
    end
  end

  assign RAS_FULL  = w_full;
  assign RAS_EMPTY = w_empty;
  assign RAS_ERR   = r_err;

`else

  logic w_unused_ret;

  assign w_unused_ret = RET;

  // Without the stack CALL is an unconditional jump and RET has no effect.
  always_comb begin
    w_pc_d  = w_pc_4;
    w_taken = 1'b0;
    if (STALL) begin
      w_pc_d = r_pc;
    end else if (CALL || w_cond) begin
      w_pc_d  = w_target;
      w_taken = 1'b1;
    end
  end

  assign RAS_FULL  = 1'b0;
  assign RAS_EMPTY = 1'b1;
  assign RAS_ERR   = 1'b0;

`endif

  // Program-counter register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_d;
    end
  end

  assign PC    = r_pc;
  assign PC_4  = w_pc_4;
  assign TAKEN = w_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 4;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, STALL, BRANCH, JUMP, ZERO, CALL, RET;
  logic [7:0]  OFFSET;
  logic [31:0] PC, PC_4;
  logic        TAKEN, RAS_FULL, RAS_EMPTY, RAS_ERR;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: PC, stack as a queue (back = newest), sticky error.
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_err;

  pc_sequencer #(
    .AW          (32),
    .OFS_W       (8),
    .RAS_DEPTH   (DEPTH),
    .RESET_VECTOR(32'h0)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .STALL    (STALL),
    .BRANCH   (BRANCH),
    .JUMP     (JUMP),
    .ZERO     (ZERO),
    .CALL     (CALL),
    .RET      (RET),
    .OFFSET   (OFFSET),
    .PC       (PC),
    .PC_4     (PC_4),
    .TAKEN    (TAKEN),
    .RAS_FULL (RAS_FULL),
    .RAS_EMPTY(RAS_EMPTY),
    .RAS_ERR  (RAS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls, check combinational outputs, advance model, check state.
  task automatic step(input bit rst, input bit st, input bit br, input bit jp, input bit zr,
                      input bit cl, input bit rt, input logic [7:0] ofs);
    logic [31:0] pc4, tgt, npc;
    int          so;
    bit          tk;
    RESET = rst; STALL = st; BRANCH = br; JUMP = jp; ZERO = zr; CALL = cl; RET = rt;
    OFFSET = ofs;
    #1;
    pc4 = m_pc + 32'd4;
    so  = $signed(ofs);
    tgt = pc4 + 32'(so * 4);
    npc = pc4;
    tk  = 1'b0;
    if (rst) begin
      npc   = 32'h0;
      m_stk = {};
      m_err = 1'b0;
    end else begin
      chk("pc_4", PC_4, pc4);
      if (st) begin
        npc = m_pc;
      end else if (RasEn && rt) begin
        if (m_stk.size() > 0) begin
          npc = m_stk[m_stk.size()-1];
          tk  = 1'b1;
          if (cl) m_stk[m_stk.size()-1] = pc4;
          else void'(m_stk.pop_back());
        end else begin
          m_err = 1'b1;
          if (cl) m_stk.push_back(pc4);
        end
      end else if (cl) begin
        npc = tgt;
        tk  = 1'b1;
        if (RasEn) begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
          end
          m_stk.push_back(pc4);
        end
      end else if (jp ^ (br & zr)) begin
        npc = tgt;
        tk  = 1'b1;
      end
      chk("taken", {31'b0, TAKEN}, {31'b0, tk});
    end
    m_pc = npc;
    @(posedge CLK);
    #1;
    chk("pc", PC, m_pc);
    chk("ras_full", {31'b0, RAS_FULL}, {31'b0, RasEn && (m_stk.size() == DEPTH)});
    chk("ras_empty", {31'b0, RAS_EMPTY}, {31'b0, !RasEn || (m_stk.size() == 0)});
    chk("ras_err", {31'b0, RAS_ERR}, {31'b0, m_err});
  endtask

  initial begin
    m_pc = 32'h0; m_err = 1'b0;
    // Reset then free-run.
    step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("rst_pc", PC, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("free_4", PC, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("free_8", PC, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("free_c", PC, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("free_10", PC, 32'h10);
    // beq taken backwards, then bne not taken.
    step(0, 0, 1, 0, 1, 0, 0, 8'hFE); chk("beq_taken", PC, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("back_10", PC, 32'h10);
    step(0, 0, 1, 1, 1, 0, 0, 8'hFE); chk("bne_fall", PC, 32'h14);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    chk("at_20", PC, 32'h20);
    // Call then return.
    step(0, 0, 0, 0, 0, 1, 0, 8'h10); chk("call_tgt", PC, 32'h64);
    step(0, 0, 0, 0, 0, 0, 1, 8'h00);
    // Five nested calls overflow a four-deep stack, then five returns.
    repeat (5) step(0, 0, 0, 0, 0, 1, 0, 8'h00);
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 8'h00);
    // Stall holds a pending call; release takes it once.
    repeat (3) step(0, 1, 0, 0, 0, 1, 0, 8'h08);
    step(0, 0, 0, 0, 0, 1, 0, 8'h08);
    step(0, 0, 0, 0, 0, 1, 1, 8'h00);
    step(0, 0, 0, 0, 0, 1, 1, 8'h00);
    // Wrap at the top of the address space.
    step(1, 0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 0, 0, 0, 8'hFE); chk("to_top", PC, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00); chk("wrap", PC, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h00);
    // Reset beats stall, call and ret together.
    step(1, 1, 0, 0, 0, 1, 1, 8'h00);
    chk("rst_over_pc", PC, 32'h0);
    chk("rst_over_err", {31'b0, RAS_ERR}, 32'h0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 32, program-counter and address width in bits (AW >= 8).
REQ-002 Parameter OFS_W, default 8, branch/jump word-offset width in bits (OFS_W <= AW-2).
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-004 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-005 Clocking SHALL be: reset RESET, synchronous, active-high; clock CLK.
REQ-006 CLK  input  1  rising-edge clock.
REQ-007 RESET  input  1  synchronous active-high reset.
REQ-008 STALL  input  1  hold PC and stack state this cycle.
REQ-009 BRANCH  input  1  conditional-branch instruction in flight.
REQ-010 JUMP  input  1  unconditional jump / inverts branch sense (beq/bne).
REQ-011 ZERO  input  1  ALU zero flag.
REQ-012 CALL  input  1  call instruction: jump to target and push return address.
REQ-013 RET  input  1  return instruction: jump to popped address.
REQ-014 OFFSET  input  OFS_W  signed word offset.
REQ-015 PC  output  AW  current program counter (registered).
REQ-016 PC_4  output  AW  PC + 4 (combinational).
REQ-017 TAKEN  output  1  combinational: non-sequential next PC selected this cycle.
REQ-018 RAS_FULL  output  1  stack holds RAS_DEPTH entries.
REQ-019 RAS_EMPTY  output  1  stack holds zero entries.
REQ-020 RAS_ERR  output  1  sticky: overflow or pop-on-empty occurred.

Function
REQ-021 Target SHALL be PC_4 + (sign-extended OFFSET << 2), all arithmetic modulo 2^AW.
REQ-022 Branch condition SHALL be JUMP ^ (BRANCH & ZERO): beq when 0/1/1, bne when 1/1/0, jump when 1/0/x.
REQ-023 Next-PC priority SHALL be: RESET > STALL > RET > CALL > branch condition > PC_4.
REQ-024 PC SHALL update only on rising CLK; a new PC is visible one cycle after its controls are sampled.
REQ-025 STALL=1 SHALL hold PC, stack contents, count and RAS_ERR unchanged; TAKEN SHALL read 0.
REQ-026 CALL (RET=0) SHALL load target into PC and push PC_4.
REQ-027 RET (CALL=0) with stack non-empty SHALL load PC with the top entry and pop it.
REQ-028 RET on empty stack SHALL advance PC to PC_4, leave count at 0, and set RAS_ERR.
REQ-029 CALL on full stack SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH, and set RAS_ERR.
REQ-030 CALL and RET together with stack non-empty SHALL load PC with the top entry and replace that entry with PC_4, count unchanged.
REQ-031 CALL and RET together on empty stack SHALL follow REQ-028, then push PC_4 (count becomes 1).
REQ-032 PC_4 SHALL wrap from 2^AW-4 to 0 with no flag.

Reset
REQ-033 On RESET: PC=RESET_VECTOR, count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0; stack contents don't-care.
REQ-034 RESET SHALL override STALL, CALL and RET in the same cycle, including mid call sequence.

Configuration
REQ-035 Macro PC_SEQUENCER_RAS_EN defined: stack present, behaviour per REQ-026..031.
REQ-036 Macro undefined: no stack storage; CALL SHALL behave as JUMP without a push; RET SHALL be ignored (sequential); RAS_FULL=0, RAS_EMPTY=1, RAS_ERR=0 constantly.

Verification
REQ-037 Reset then 3 free-running cycles -> PC 0x0, 0x4, 0x8, 0xC.
REQ-038 PC=0x10, BRANCH=1, ZERO=1, JUMP=0, OFFSET=0xFE -> next PC 0x0C; same with JUMP=1 -> next PC 0x14.
REQ-039 PC=0x20, CALL, OFFSET=0x10 -> PC 0x64; next RET -> PC 0x24, RAS_EMPTY=1.
REQ-040 RAS_DEPTH=4, five nested CALLs -> RAS_FULL=1, RAS_ERR=1; four RETs return the four newest addresses; fifth RET -> PC_4.
REQ-041 STALL=1 with CALL=1 for 3 cycles -> PC and RAS_EMPTY unchanged; STALL released -> call taken once.
REQ-042 PC=0xFFFFFFFC, no control -> next PC 0x0; RESET asserted with RET pending -> PC=RESET_VECTOR, RAS_ERR=0.
